// File: rtl/highscore_table_if.sv
// Bus between the reaction-game logic and the high-score table: submit/clear
// requests in, read port and insertion status out.
interface highscore_table_if #(
   parameter int DATA_W = 14,
   parameter int IDX_W  = 3
);
   logic              submit;
   logic [DATA_W-1:0] score;
   logic              clear;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] best;
   logic              busy;
   logic              done;
   logic              placed;
   logic [IDX_W-1:0]  rank;

   modport master (
      output submit, score, clear, rd_idx,
      input  rd_data, best, busy, done, placed, rank
   );

   modport slave (
      input  submit, score, clear, rd_idx,
      output rd_data, best, busy, done, placed, rank
   );
endinterface

// File: rtl/highscore_table.sv
// Top-N best reaction-time table, ascending (lower is better). A submitted score
// is inserted by a one-compare-per-cycle search followed by a one-write-per-cycle shift.
module highscore_table #(
   parameter int          DATA_W    = 14,
   parameter int          DEPTH     = 4,
   parameter int          IDX_W     = 3,
   parameter int unsigned EMPTY_VAL = 9999
) (
   input  logic iCLK,
   input  logic iRST_N,
   highscore_table_if.slave bus
);
   localparam logic [DATA_W-1:0] EMPTY = DATA_W'(EMPTY_VAL);
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0]  NONE  = IDX_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEARCH, SHIFT, DONE} state_t;

   state_t            state_q;
   logic [DATA_W-1:0] tbl_q [DEPTH];
   logic [DATA_W-1:0] s_q;
   logic [IDX_W-1:0]  idx_q, pos_q, j_q, rank_q;
   logic              busy_q, done_q, placed_q;
   logic [DATA_W-1:0] cur_d, rd_d;

   // Entry under comparison during SEARCH.
   always_comb begin
      cur_d = tbl_q[0];
      for (int i = 0; i < DEPTH; i++)
         if (idx_q == IDX_W'(i)) cur_d = tbl_q[i];
   end

   // Out-of-range read indices return the empty sentinel.
   always_comb begin
      rd_d = EMPTY;
      for (int i = 0; i < DEPTH; i++)
         if (bus.rd_idx == IDX_W'(i)) rd_d = tbl_q[i];
   end

   assign bus.rd_data = rd_d;
   assign bus.best    = tbl_q[0];
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.placed  = placed_q;
   assign bus.rank    = rank_q;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= EMPTY;
         state_q  <= IDLE;
         s_q      <= '0;
         idx_q    <= '0;
         pos_q    <= '0;
         j_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         placed_q <= 1'b0;
         rank_q   <= NONE;
      end else if (bus.clear) begin
         // Wipe and abort; placed/rank keep the last reported result.
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= EMPTY;
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.submit) begin
                  s_q   <= bus.score;
                  idx_q <= '0;
                  if (bus.score >= EMPTY) begin
                     state_q  <= DONE;
                     done_q   <= 1'b1;
                     placed_q <= 1'b0;
                     rank_q   <= NONE;
                  end else begin
                     state_q <= SEARCH;
                     busy_q  <= 1'b1;
                  end
               end
            end
            SEARCH: begin
               // Strict compare: an equal score lands after the existing one.
               if (s_q < cur_d) begin
                  pos_q   <= idx_q;
                  j_q     <= LAST;
                  state_q <= SHIFT;
               end else if (idx_q == LAST) begin
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  placed_q <= 1'b0;
                  rank_q   <= NONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            SHIFT: begin
               for (int i = 1; i < DEPTH; i++)
                  if (j_q == IDX_W'(i) && j_q != pos_q) tbl_q[i] <= tbl_q[i-1];
               for (int i = 0; i < DEPTH; i++)
                  if (j_q == IDX_W'(i) && j_q == pos_q) tbl_q[i] <= s_q;
               if (j_q == pos_q) begin
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  placed_q <= 1'b1;
                  rank_q   <= pos_q;
               end else begin
                  j_q <= j_q - 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
